// File: rtl/if_pkg.sv
// if_pkg: shared counter encodings, default reset PC and BHT entry type for the fetch stage
package if_pkg;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0] ctr;
  } bht_entry_t;
endpackage

// File: rtl/bht_table.sv
// bht_table: direct-mapped table of 2-bit counters and targets; fetch read port, update train port
module bht_table import if_pkg::*; #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] rd_word,
  output logic [1:0]  rd_ctr,
  output logic [31:0] rd_target,
  input  logic        upd_valid,
  input  logic [29:0] upd_word,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam bht_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
  bht_entry_t tbl_q [ENTRIES];
  bht_entry_t tbl_d [ENTRIES];
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [29:0] r_tag, w_tag;
  bht_entry_t r_e, w_e;
  logic r_hit, w_hit;
  logic [1:0] ctr_up, ctr_dn;
  assign r_idx = rd_word[IDX_W-1:0];
  assign r_tag = rd_word >> IDX_W;
  assign r_e = tbl_q[r_idx];
  assign r_hit = r_e.valid && r_e.tag == r_tag;
  assign rd_ctr = r_hit ? r_e.ctr : CTR_WNT;
  assign rd_target = r_e.target;
  assign w_idx = upd_word[IDX_W-1:0];
  assign w_tag = upd_word >> IDX_W;
  assign w_e = tbl_q[w_idx];
  assign w_hit = w_e.valid && w_e.tag == w_tag;
  assign ctr_up = (w_e.ctr == CTR_ST) ? CTR_ST : w_e.ctr + 2'd1;
  assign ctr_dn = (w_e.ctr == CTR_SNT) ? CTR_SNT : w_e.ctr - 2'd1;
  // a taken miss allocates over whatever lives at the index; a not-taken miss leaves it alone
  always_comb begin
    tbl_d = tbl_q;
    if (upd_valid && upd_taken)
      tbl_d[w_idx] = '{valid: 1'b1, tag: w_tag, target: upd_target, ctr: w_hit ? ctr_up : CTR_WT};
    else if (upd_valid && w_hit)
      tbl_d[w_idx].ctr = ctr_dn;
  end
  always_ff @(posedge clk) begin
    if (rst)
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= RST_ENTRY;
    else
      tbl_q <= tbl_d;
  end
endmodule

// File: rtl/if_fetch_bht.sv
// if_fetch_bht: fetch PC register and next-PC mux with optional BHT prediction (IF_BHT_PREDICT_EN)
module if_fetch_bht import if_pkg::*; #(
  parameter int BHT_ENTRIES = 16,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_use,
  input  logic        predict_fail,
  input  logic [31:0] correct_pc,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic [31:0] pc_predict,
  output logic [1:0]  binary_predict
);
  logic [31:0] pc_q, pc_d;
  assign pc = pc_q;
  assign pc_4 = pc_q + 32'd4;
`ifdef IF_BHT_PREDICT_EN
  logic [31:0] bht_target;
  logic unused_lo;
  assign unused_lo = ^update_pc[1:0];
  bht_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk(clk),
    .rst(rst),
    .rd_word(pc_q[31:2]),
    .rd_ctr(binary_predict),
    .rd_target(bht_target),
    .upd_valid(update_valid),
    .upd_word(update_pc[31:2]),
    .upd_taken(update_taken),
    .upd_target(update_target)
  );
  assign pc_predict = binary_predict[1] ? bht_target : pc_4;
`else
  logic unused_upd;
  assign unused_upd = ^{update_valid, update_pc, update_taken, update_target};
  assign binary_predict = CTR_WNT;
  assign pc_predict = pc_4;
`endif
  always_comb pc_d = predict_fail ? correct_pc : (load_use || !en) ? pc_q : pc_predict;
  always_ff @(posedge clk) pc_q <= rst ? RESET_PC : pc_d;
endmodule

// File: tb/tb_if_fetch_bht.sv
// tb_if_fetch_bht: directed checks of PC sequencing, redirect priority and BHT training
module tb_if_fetch_bht;
`ifdef IF_BHT_PREDICT_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, en, load_use, predict_fail, update_valid, update_taken;
  logic [31:0] correct_pc, update_pc, update_target;
  logic [31:0] pc, pc_4, pc_predict;
  logic [1:0] binary_predict;
  int checks = 0;
  int failures = 0;
  logic [31:0] x;
  always #5 clk = ~clk;
  if_fetch_bht #(.BHT_ENTRIES(16), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .en(en), .load_use(load_use),
    .predict_fail(predict_fail), .correct_pc(correct_pc),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .pc(pc), .pc_4(pc_4), .pc_predict(pc_predict), .binary_predict(binary_predict)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic upd(input logic v, input logic [31:0] a, input logic t, input logic [31:0] tg);
    update_valid = v;
    update_pc = a;
    update_taken = t;
    update_target = tg;
  endtask
  task automatic redirect(input logic [31:0] a);
    predict_fail = 1'b1;
    correct_pc = a;
    step();
    predict_fail = 1'b0;
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; load_use = 1'b0; predict_fail = 1'b0; correct_pc = '0;
    upd(1'b0, '0, 1'b0, '0);
    step(); step();
    rst = 1'b0;
    chk("rst_pc", pc, 32'h100);
    chk("rst_pc4", pc_4, 32'h104);
    chk("rst_pred", pc_predict, 32'h104);
    chk("rst_bp", {30'd0, binary_predict}, 32'd1);
    en = 1'b1;
    step(); chk("seq1", pc, 32'h104);
    step(); chk("seq2", pc, 32'h108);
    en = 1'b0;
    upd(1'b1, 32'h10, 1'b1, 32'h40);
    step();
    upd(1'b0, '0, 1'b0, '0);
    load_use = 1'b1;
    redirect(32'h10);
    load_use = 1'b0;
    chk("redir_override", pc, 32'h10);
    chk("alloc_bp", {30'd0, binary_predict}, P ? 32'd2 : 32'd1);
    chk("alloc_pred", pc_predict, P ? 32'h40 : 32'h14);
    upd(1'b1, 32'h10, 1'b1, 32'h40);
    chk("rbw_bp", {30'd0, binary_predict}, P ? 32'd2 : 32'd1);
    step(); chk("tk1_bp", {30'd0, binary_predict}, P ? 32'd3 : 32'd1);
    step(); step(); chk("tk3_sat", {30'd0, binary_predict}, P ? 32'd3 : 32'd1);
    upd(1'b1, 32'h10, 1'b0, 32'h0);
    step(); chk("nt1_bp", {30'd0, binary_predict}, P ? 32'd2 : 32'd1);
    chk("nt1_tgt", pc_predict, P ? 32'h40 : 32'h14);
    step(); chk("nt2_bp", {30'd0, binary_predict}, 32'd1);
    chk("nt2_pred", pc_predict, 32'h14);
    upd(1'b1, 32'h10, 1'b1, 32'h40);
    step();
    upd(1'b0, '0, 1'b0, '0);
    chk("retake_pred", pc_predict, P ? 32'h40 : 32'h14);
    en = 1'b1;
    step();
    x = P ? 32'h40 : 32'h14;
    chk("taken_pc", pc, x);
    load_use = 1'b1;
    step(); chk("lu1", pc, x);
    step(); chk("lu2", pc, x);
    step(); chk("lu3", pc, x);
    load_use = 1'b0;
    step(); chk("lu_resume", pc, x + 32'd4);
    en = 1'b0; load_use = 1'b1;
    redirect(32'h80);
    load_use = 1'b0;
    chk("redir_80", pc, 32'h80);
    redirect(32'h50);
    chk("alias_bp", {30'd0, binary_predict}, 32'd1);
    chk("alias_pred", pc_predict, 32'h54);
    redirect(32'hFFFF_FFFC);
    chk("wrap_pc4", pc_4, 32'h0);
    en = 1'b1;
    step(); chk("wrap_pc", pc, 32'h0);
    en = 1'b0;
    rst = 1'b1; predict_fail = 1'b1; correct_pc = 32'h200;
    upd(1'b1, 32'h10, 1'b1, 32'h40);
    step();
    rst = 1'b0; predict_fail = 1'b0;
    upd(1'b0, '0, 1'b0, '0);
    chk("midrst_pc", pc, 32'h100);
    redirect(32'h10);
    chk("midrst_bp", {30'd0, binary_predict}, 32'd1);
    chk("midrst_pred", pc_predict, 32'h14);
    upd(1'b1, 32'h10, 1'b0, 32'h0);
    step();
    upd(1'b0, '0, 1'b0, '0);
    chk("ntmiss_bp", {30'd0, binary_predict}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch_bht.md
# if_fetch_bht

Instruction-fetch stage: owns the program counter and a direct-mapped branch history table (BHT) of 2-bit saturating counters with branch targets. Each cycle it presents the fetch PC to instruction memory and computes the predicted next PC, the prediction counter and PC+4. These values are the direct inputs of the IF/ID pipeline register. Mispredictions resolved later in the pipeline redirect the PC and train the table.

## Interface
Parameters:
- `BHT_ENTRIES`, default 16: table depth; power of two, ≥2; `IDX_W = log2(BHT_ENTRIES)`.
- `RESET_PC`, default 32'h0000_0000: PC after reset; word aligned.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: pipeline advance enable.
- `load_use`, input, 1: hazard stall; holds the PC.
- `predict_fail`, input, 1: misprediction redirect.
- `correct_pc`, input, 32: redirect target; valid with `predict_fail`.
- `update_valid`, input, 1: a branch resolved this cycle.
- `update_pc`, input, 32: PC of the resolved branch.
- `update_taken`, input, 1: actual branch direction.
- `update_target`, input, 32: actual taken target.
- `pc`, output, 32: fetch address to instruction memory.
- `pc_4`, output, 32: `pc + 4`, modulo 2^32.
- `pc_predict`, output, 32: predicted next PC.
- `binary_predict`, output, 2: counter value used for the prediction.

## Operation
- Entry fields: `valid`, `tag` (`pc[31:IDX_W+2]`), `target[31:0]`, `ctr[1:0]`.
- Index: `pc[IDX_W+1:2]`.
- Lookup is combinational on `pc`. A hit requires `valid` and a tag match.
- On a hit:
  - `binary_predict = ctr`.
  - `pc_predict = ctr[1] ? target : pc_4`.
- On a miss: `binary_predict = 2'b01` and `pc_predict = pc_4`.
- PC register priority, evaluated at each rising `clk`:
  1. `rst`: `pc <= RESET_PC`.
  2. `predict_fail`: `pc <= correct_pc`. This overrides `load_use` and `!en`.
  3. `load_use` or `!en`: hold `pc`.
  4. Otherwise: `pc <= pc_predict`.
- Training happens when `update_valid` is asserted. The entry is selected by the `update_pc` index.
  - Tag hit, taken: `ctr` saturating increment (`11` stays `11`) and `target <= update_target`.
  - Tag hit, not taken: `ctr` saturating decrement (`00` stays `00`). `target` is unchanged.
  - Miss, taken: allocate. Set `valid=1`, `tag` from `update_pc`, `target=update_target`, `ctr=2'b10`. Any existing entry at that index is overwritten.
  - Miss, not taken: no change.
- Training is independent of `en`, `load_use` and `predict_fail`.
- Arithmetic:
  - `pc_4` wraps modulo 2^32 (`32'hFFFF_FFFC → 0`).
  - PC bits [1:0] are carried through unmodified; no alignment checking is done.

## Timing
- Reset values:
  - `pc = RESET_PC` and `pc_4 = RESET_PC+4`.
  - `pc_predict = RESET_PC+4` and `binary_predict = 2'b01`.
  - All `valid = 0` and all `ctr = 2'b01`.
- Outputs are combinational from the `pc` register and the table, stable one clock after each PC update.
- Table writes are registered. A lookup in the same cycle as a write to the same index returns the pre-write contents. The new contents are visible the next cycle.
- Redirect latency: `predict_fail` in cycle N makes `pc = correct_pc` in cycle N+1.
- `rst` asserted mid-operation: the table is invalidated and the PC reloaded in the same edge. Any simultaneous update or redirect is discarded.

## Configuration
- Macro `IF_BHT_PREDICT_EN`.
- Defined: the table and the lookup/training logic described above are built.
- Undefined: no table storage.
  - `pc_predict = pc_4` and `binary_predict = 2'b01` always.
  - `update_*` inputs are ignored.
  - PC priority is unchanged.

## Structure
- Shared package `if_pkg`:
  - Counter encodings `CTR_SNT=2'b00`, `CTR_WNT=2'b01`, `CTR_WT=2'b10`, `CTR_ST=2'b11`.
  - Default `RESET_PC`.
  - BHT entry struct type (valid/tag/target/ctr).
- One sub-module, `bht_table`: table storage, read port on the fetch index, write/training port on the update index. The top level holds the PC register and the next-PC mux.

## Test plan
- Reset with `RESET_PC=32'h100` → `pc=32'h100`, `pc_4=32'h104`, `pc_predict=32'h104`, `binary_predict=2'b01`; with `en=1`, the PC steps by 4 each cycle.
- Taken update at `update_pc=32'h10`, `update_target=32'h40`; later fetch at `32'h10` → `binary_predict=2'b10`, `pc_predict=32'h40`, next `pc=32'h40`.
- Training sequence at `32'h10`:
  - After allocation, three more taken updates → `ctr` stays `11`.
  - Then two not-taken updates → `ctr=01`; fetch at `32'h10` predicts `32'h14`.
- `predict_fail=1`, `correct_pc=32'h80`, with `load_use=1` and `en=0` simultaneously → `pc=32'h80` next cycle.
- `load_use=1` for 3 cycles → `pc` constant, then resumes at `pc_predict`.
- Aliasing (`BHT_ENTRIES=16`): allocate entry at `32'h10`, then fetch `32'h50` (same index, different tag) → miss, `binary_predict=2'b01`, `pc_predict=32'h54`.
